pwm_capture: RTL

- Receive-side counterpart to the PWM generator blocks: measures an incoming PWM waveform on a single pin.
- Reports period, high time and signed high-minus-low difference, in clk cycles.
- Feeds the vin_* input path to the host: host reads measured duty or speed, not commands it.
- No division in hardware; the host derives the duty ratio from the outputs.

---
 rtl/pwm_capture.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM input capture: measures period, high time and high-minus-low
// difference of a single asynchronous PWM pin, in clk cycles.
module pwm_capture #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pwm_in,
    output logic [WIDTH-1:0]        period,
    output logic [WIDTH-1:0]        high_time,
    output logic signed [WIDTH-1:0] diff,
    output logic                    valid,
    output logic                    timeout,
    output logic                    level
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_HIT = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FALL,
        WAIT_RISE
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    s_d_q, s_d_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0]        period_q, period_d;
    logic [WIDTH-1:0]        high_q, high_d;
    logic [WIDTH-1:0]        diff_q, diff_d;
    logic                    valid_q, valid_d;
    logic                    timeout_q, timeout_d;

    logic s;
    logic rise;
    logic fall;
    logic to_hit;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d_q;
    assign fall   = ~s & s_d_q;
    assign to_hit = (cnt_q == CNT_HIT) && !rise && !fall;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_d_d     = s;
        state_d   = state_q;
        hi_lat_d  = hi_lat_q;
        period_d  = period_q;
        high_d    = high_q;
        diff_d    = diff_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        // Counter restarts at 1 on each rise and saturates instead of wrapping.
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = CNT_MAX;
        end

        if (fall) begin
            hi_lat_d = cnt_q;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_d   = WAIT_FALL;
                    period_d  = cnt_q;
                    high_d    = hi_lat_q;
                    diff_d    = {hi_lat_q[WIDTH-2:0], 1'b0} - cnt_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A static input forces the block back to a known, cleared state.
        if (to_hit) begin
            state_d   = IDLE;
            period_d  = '0;
            high_d    = '0;
            diff_d    = '0;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            cnt_q     <= '0;
            hi_lat_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            diff_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            diff_q    <= diff_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign diff      = diff_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = s;

endmodule
